// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM states, frame
// length, common keyboard command bytes and the frame builder.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INHIBIT = 3'd1,
    ST_RTS     = 3'd2,
    ST_DATA    = 3'd3,
    ST_ACK     = 3'd4,
    ST_WAITREL = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERR     = 3'd7
  } state_t;

  // Bits shifted by the host after the start bit: 8 data, parity, stop.
  localparam int unsigned PS2_FRAME_BITS = 10;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  // {stop, odd parity, data}; bit 0 goes on the wire first.
  function automatic logic [9:0] make_frame(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction

endpackage

// File: rtl/ps2_sync_fall.sv
// 2-FF synchroniser with falling-edge detect for a raw PS/2 line.
// Ports:
//   clock, reset : system clock, async active-high reset
//   pin          : asynchronous line input
//   level        : synchronised line level (resets high = idle line)
//   fall         : 1-cycle pulse, aligned with level going 1 -> 0
module ps2_sync_fall (
  input  logic clock,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic fall
);

  logic meta;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta  <= 1'b1;
      level <= 1'b1;
      fall  <= 1'b0;
    end else begin
      meta  <= pin;
      level <= meta;
      // Registered so fall is high exactly in the cycle level first reads 0.
      fall  <= level & ~meta;
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Inhibits the bus, issues request-to-send,
// shifts data/parity/stop on device clock falls and checks the device ACK.
// Ports:
//   clock, reset           : 25 MHz system clock, async active-high reset
//   tx_data, tx_start      : command byte and 1-cycle request (IDLE only)
//   tx_busy                : high while a request is in progress
//   tx_done, tx_error      : 1-cycle completion pulses (ACK / timeout or NACK)
//   ps2_clk_i, ps2_dat_i   : raw PS/2 lines
//   ps2_clk_oe, ps2_dat_oe : 1 = pull the line low
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 2500,
  parameter int unsigned TIMEOUT_CYCLES = 375000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES
                                                                      : INHIBIT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);

  state_t           state;
  logic [9:0]       shreg;
  logic [3:0]       bitcnt;
  logic [CNT_W-1:0] cnt;
  logic             clk_lvl;
  logic             clk_fall;
  logic             dat_meta;
  logic             dat_lvl;
  logic             timeout_c;

  ps2_sync_fall u_clk_sync (
    .clock (clock),
    .reset (reset),
    .pin   (ps2_clk_i),
    .level (clk_lvl),
    .fall  (clk_fall)
  );

  // Data line needs only a synchronised level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dat_meta <= 1'b1;
      dat_lvl  <= 1'b1;
    end else begin
      dat_meta <= ps2_dat_i;
      dat_lvl  <= dat_meta;
    end
  end

  assign timeout_c = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Transmit FSM; all outputs registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bitcnt     <= '0;
      cnt        <= '0;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      tx_error   <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tx_start) begin
            state      <= ST_INHIBIT;
            cnt        <= '0;
            tx_busy    <= 1'b1;
            shreg      <= make_frame(tx_data);
            ps2_clk_oe <= 1'b1;
            ps2_dat_oe <= 1'b0;
          end
        end
        ST_INHIBIT: begin
          if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
            state      <= ST_RTS;
            cnt        <= '0;
            bitcnt     <= '0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        // The first device fall after RTS already carries d0.
        ST_RTS, ST_DATA: begin
          if (clk_fall) begin
            ps2_dat_oe <= ~shreg[0];
            shreg      <= {1'b0, shreg[9:1]};
            bitcnt     <= bitcnt + 4'd1;
            cnt        <= '0;
            state      <= (bitcnt == 4'(PS2_FRAME_BITS - 1)) ? ST_ACK : ST_DATA;
          end else if (timeout_c) begin
            state      <= ST_ERR;
            tx_error   <= 1'b1;
            cnt        <= '0;
            ps2_dat_oe <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_ACK: begin
          if (clk_fall) begin
            cnt <= '0;
            if (!dat_lvl) begin
              state <= ST_WAITREL;
            end else begin
              state    <= ST_ERR;
              tx_error <= 1'b1;
            end
          end else if (timeout_c) begin
            state    <= ST_ERR;
            tx_error <= 1'b1;
            cnt      <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_WAITREL: begin
          if (clk_lvl && dat_lvl) begin
            state   <= ST_DONE;
            tx_done <= 1'b1;
            cnt     <= '0;
          end else if (clk_fall) begin
            cnt <= '0;
          end else if (timeout_c) begin
            state    <= ST_ERR;
            tx_error <= 1'b1;
            cnt      <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE, ST_ERR: begin
          state      <= ST_IDLE;
          tx_busy    <= 1'b0;
          cnt        <= '0;
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
        end
        default: begin
          state      <= ST_IDLE;
          tx_busy    <= 1'b0;
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a small PS/2 device model.
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int unsigned INH = 50;
  localparam int unsigned TMO = 600;
  localparam int unsigned H   = 20;   // device clock half period, in system cycles

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       ps2_clk_line, ps2_dat_line;

  assign ps2_clk_line = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_line = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clock      (clock),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .ps2_clk_i  (ps2_clk_line),
    .ps2_dat_i  (ps2_dat_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Background pulse / inhibit monitors.
  int   done_cnt = 0, err_cnt = 0, both_cnt = 0, long_cnt = 0;
  int   inh_len = 0, last_inh = 0, inh_runs = 0;
  logic prev_done = 1'b0, prev_err = 1'b0, prev_clkoe = 1'b0;

  always @(negedge clock) begin
    if (tx_done) done_cnt++;
    if (tx_error) err_cnt++;
    if (tx_done && tx_error) both_cnt++;
    if ((tx_done && prev_done) || (tx_error && prev_err)) long_cnt++;
    if (ps2_clk_oe) inh_len++;
    else if (prev_clkoe) begin
      last_inh = inh_len;
      inh_len  = 0;
      inh_runs++;
    end
    prev_done  = tx_done;
    prev_err   = tx_error;
    prev_clkoe = ps2_clk_oe;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [9:0] bits;
  bit         oe10, ok, pok;
  logic       pd, pe, b_at, b_next, coe, doe;
  int         d0, e0, r0, cyc;

  task automatic start_tx(input logic [7:0] d);
    @(negedge clock);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clock);
    tx_start = 1'b0;
  endtask

  // Device model: waits for RTS, then generates nfalls clock pulses,
  // sampling data on rising edges and driving ACK unless nack.
  task automatic bfm(input int nfalls, input bit nack, output logic [9:0] b,
                     output bit oe_late, output bit found);
    b = '0; oe_late = 1'b0; found = 1'b0;
    for (int i = 0; i < int'(INH) + 100; i++) begin
      @(negedge clock);
      if (ps2_clk_line && !ps2_dat_line) begin
        found = 1'b1;
        break;
      end
    end
    if (found) begin
      for (int k = 1; k <= nfalls; k++) begin
        repeat (H) @(negedge clock);
        dev_clk_low = 1'b1;
        repeat (H) @(negedge clock);
        if (k <= 10) b[k-1] = ps2_dat_line;
        if (k >= 10) oe_late = oe_late | ps2_dat_oe;
        dev_clk_low = 1'b0;
        if (k == 10 && !nack) begin
          repeat (H/2) @(negedge clock);
          oe_late = oe_late | ps2_dat_oe;
          dev_dat_low = 1'b1;
        end
        if (k == 11) dev_dat_low = 1'b0;
      end
    end
  endtask

  task automatic wait_pulse(input int bound, output bit got, output logic p_done,
                            output logic p_err, output logic busy_at, output logic busy_next,
                            output logic c_oe, output logic d_oe);
    got = 1'b0; p_done = 1'b0; p_err = 1'b0; busy_at = 1'b0; busy_next = 1'b1;
    c_oe = 1'b1; d_oe = 1'b1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clock);
      if (tx_done || tx_error) begin
        got = 1'b1;
        break;
      end
    end
    if (got) begin
      p_done  = tx_done;
      p_err   = tx_error;
      busy_at = tx_busy;
      @(negedge clock);
      busy_next = tx_busy;
      c_oe      = ps2_clk_oe;
      d_oe      = ps2_dat_oe;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_checks++;
    if ({tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 00000",
               {tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe});
    end
    reset = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++;
    if ({tx_busy, ps2_clk_oe, ps2_dat_oe} !== 3'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b want 000", {tx_busy, ps2_clk_oe, ps2_dat_oe});
    end
  endtask

  task automatic test_send_ed();
    d0 = done_cnt; e0 = err_cnt; r0 = inh_runs;
    fork
      begin start_tx(CMD_SET_LEDS); bfm(11, 1'b0, bits, oe10, ok); end
      wait_pulse(int'(INH) + 1500, pok, pd, pe, b_at, b_next, coe, doe);
    join
    repeat (4) @(negedge clock);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ed_rts: got none want rts seen"); end
    n_checks++;
    if (inh_runs != r0 + 1 || last_inh != int'(INH)) begin
      n_fail++;
      $display("FAIL ed_inhibit_len: got %0d cycles (%0d runs) want %0d (1 run)",
               last_inh, inh_runs - r0, INH);
    end
    n_checks++;
    if (bits !== 10'h3ED) begin
      n_fail++; $display("FAIL ed_frame: got %h want 3ed", bits);
    end
    n_checks++;
    if (!pok || pd !== 1'b1 || pe !== 1'b0 || b_at !== 1'b1) begin
      n_fail++; $display("FAIL ed_pulse: got done=%b err=%b busy=%b want 1 0 1", pd, pe, b_at);
    end
    n_checks++;
    if (b_next !== 1'b0) begin
      n_fail++; $display("FAIL ed_busy_after: got %b want 0", b_next);
    end
    n_checks++;
    if (done_cnt - d0 != 1 || err_cnt != e0) begin
      n_fail++;
      $display("FAIL ed_pulse_count: got done=%0d err=%0d want 1 0", done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_parity_07();
    d0 = done_cnt;
    fork
      begin start_tx(8'h07); bfm(11, 1'b0, bits, oe10, ok); end
      wait_pulse(int'(INH) + 1500, pok, pd, pe, b_at, b_next, coe, doe);
    join
    repeat (4) @(negedge clock);
    n_checks++;
    if (bits !== 10'h207) begin
      n_fail++; $display("FAIL p07_frame: got %h want 207", bits);
    end
    n_checks++;
    if (oe10 !== 1'b0) begin
      n_fail++; $display("FAIL p07_dat_oe_after_stop: got %b want 0", oe10);
    end
    n_checks++;
    if (!pok || pd !== 1'b1 || done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL p07_done: got pulse=%b count=%0d want 1 1", pd, done_cnt - d0);
    end
  endtask

  task automatic test_nack();
    d0 = done_cnt; e0 = err_cnt;
    fork
      begin start_tx(CMD_RESET); bfm(11, 1'b1, bits, oe10, ok); end
      wait_pulse(int'(INH) + 1500, pok, pd, pe, b_at, b_next, coe, doe);
    join
    repeat (4) @(negedge clock);
    n_checks++;
    if (bits !== 10'h3FF) begin
      n_fail++; $display("FAIL nack_frame: got %h want 3ff", bits);
    end
    n_checks++;
    if (!pok || pe !== 1'b1 || pd !== 1'b0) begin
      n_fail++; $display("FAIL nack_pulse: got err=%b done=%b want 1 0", pe, pd);
    end
    n_checks++;
    if ({b_next, coe, doe} !== 3'b000) begin
      n_fail++; $display("FAIL nack_released: got busy/clk/dat=%b want 000", {b_next, coe, doe});
    end
    n_checks++;
    if (err_cnt - e0 != 1 || done_cnt != d0) begin
      n_fail++;
      $display("FAIL nack_count: got err=%0d done=%0d want 1 0", err_cnt - e0, done_cnt - d0);
    end
  endtask

  task automatic test_timeout_rts();
    bit found, got;
    d0 = done_cnt; e0 = err_cnt;
    found = 1'b0; got = 1'b0; cyc = 0;
    start_tx(CMD_RESET);
    for (int i = 0; i < int'(INH) + 100; i++) begin
      @(negedge clock);
      if (ps2_dat_oe) begin found = 1'b1; break; end
    end
    if (found) begin
      for (int i = 0; i < int'(TMO) + 50; i++) begin
        @(negedge clock);
        cyc++;
        if (tx_error) begin got = 1'b1; break; end
      end
    end
    n_checks++;
    if (!got || cyc != int'(TMO)) begin
      n_fail++; $display("FAIL rts_timeout_cycles: got %0d (seen=%b) want %0d", cyc, got, TMO);
    end
    n_checks++;
    if (tx_done !== 1'b0 || ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL rts_timeout_lines: got done/clk/dat=%b want 000",
               {tx_done, ps2_clk_oe, ps2_dat_oe});
    end
    @(negedge clock);
    n_checks++;
    if (tx_busy !== 1'b0) begin
      n_fail++; $display("FAIL rts_timeout_busy: got %b want 0", tx_busy);
    end
    repeat (3) @(negedge clock);
    n_checks++;
    if (err_cnt - e0 != 1 || done_cnt != d0) begin
      n_fail++;
      $display("FAIL rts_timeout_count: got err=%0d done=%0d want 1 0", err_cnt - e0, done_cnt - d0);
    end
  endtask

  task automatic test_timeout_data();
    bit got;
    d0 = done_cnt; e0 = err_cnt; r0 = inh_runs;
    got = 1'b0; cyc = 0;
    fork
      begin start_tx(8'h10); bfm(5, 1'b0, bits, oe10, ok); end
      begin
        // 0x10: dat_oe first drops at fall 5 (d4 = 1).
        bit hi, lo;
        hi = 1'b0; lo = 1'b0;
        for (int i = 0; i < int'(INH) + 100; i++) begin
          @(negedge clock);
          if (ps2_dat_oe) begin hi = 1'b1; break; end
        end
        for (int i = 0; hi && i < 12 * int'(H) + 300; i++) begin
          @(negedge clock);
          if (!ps2_dat_oe) begin lo = 1'b1; break; end
        end
        for (int i = 0; lo && i < int'(TMO) + 50; i++) begin
          @(negedge clock);
          cyc++;
          if (tx_error) begin got = 1'b1; break; end
        end
      end
      begin
        repeat (INH + 300) @(negedge clock);
        start_tx(CMD_SET_LEDS);
      end
    join
    n_checks++;
    if (bits[4:0] !== 5'b10000) begin
      n_fail++; $display("FAIL data_timeout_bits: got %b want 10000", bits[4:0]);
    end
    n_checks++;
    if (!got || cyc != int'(TMO)) begin
      n_fail++; $display("FAIL data_timeout_cycles: got %0d (seen=%b) want %0d", cyc, got, TMO);
    end
    repeat (INH + 20) @(negedge clock);
    n_checks++;
    if (inh_runs != r0 + 1 || tx_busy !== 1'b0 || ps2_clk_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_start_ignored: got runs=%0d busy=%b clk_oe=%b want 1 0 0",
               inh_runs - r0, tx_busy, ps2_clk_oe);
    end
    n_checks++;
    if (err_cnt - e0 != 1 || done_cnt != d0) begin
      n_fail++;
      $display("FAIL data_timeout_count: got err=%0d done=%0d want 1 0", err_cnt - e0, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid_frame();
    start_tx(8'h55);
    bfm(4, 1'b0, bits, oe10, ok);
    @(negedge clock);
    n_checks++;
    if (bits[3:0] !== 4'b0101 || ps2_dat_oe !== 1'b1 || tx_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_frame_state: got bits=%b dat_oe=%b busy=%b want 0101 1 1",
               bits[3:0], ps2_dat_oe, tx_busy);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({ps2_clk_oe, ps2_dat_oe, tx_busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL async_reset: got clk/dat/busy=%b want 000", {ps2_clk_oe, ps2_dat_oe, tx_busy});
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    d0 = done_cnt;
    fork
      begin start_tx(CMD_ENABLE); bfm(11, 1'b0, bits, oe10, ok); end
      wait_pulse(int'(INH) + 1500, pok, pd, pe, b_at, b_next, coe, doe);
    join
    repeat (4) @(negedge clock);
    n_checks++;
    if (bits !== 10'h2F4) begin
      n_fail++; $display("FAIL f4_frame: got %h want 2f4", bits);
    end
    n_checks++;
    if (!pok || pd !== 1'b1 || b_next !== 1'b0 || done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL f4_done: got pulse=%b busy_after=%b count=%0d want 1 0 1",
               pd, b_next, done_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_parity_07();
    test_nack();
    test_timeout_rts();
    test_timeout_data();
    test_reset_mid_frame();
    n_checks++;
    if (both_cnt != 0 || long_cnt != 0) begin
      n_fail++;
      $display("FAIL pulse_shape: got both=%0d long=%0d want 0 0", both_cnt, long_cnt);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
